// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the frame sequencer slice.
// Holds the pixel and word widths, the default frame geometry and the
// 3-bit state encoding. Also holds a small helper for sizing counters.
package frame_sequencer_pkg;

  localparam int PIXEL_SIZE = 24;  // packed RGB, 8 bits per channel
  localparam int WORD_SIZE  = 8;   // one colour channel

  localparam int DEFAULT_FRAME_WIDTH  = 550;
  localparam int DEFAULT_FRAME_HEIGHT = 480;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VBLANK = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBLANK = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Largest of three values; used to size the shared phase timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Valid/ready RGB pixel stream between a pixel source and the sequencer.
//   in_valid : source has a pixel (master -> slave)
//   in_data  : RGB pixel (master -> slave)
//   in_ready : sequencer accepts the pixel this cycle (slave -> master)
interface frame_sequencer_if #(
  parameter int DW = frame_sequencer_pkg::PIXEL_SIZE
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/frame_sequencer_coord_counter.sv
// Raster x/y counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear to (0,0), has priority over en
//   en           : advance one position
//   x, y         : current column / row
//   last_col     : x is at WIDTH-1
//   last_row     : y is at HEIGHT-1
// x wraps WIDTH-1 -> 0 and bumps y; y wraps HEIGHT-1 -> 0.
module frame_sequencer_coord_counter #(
  parameter int CW     = 16,
  parameter int WIDTH  = 550,
  parameter int HEIGHT = 480
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          last_col,
  output logic          last_row
);

  localparam logic [CW-1:0] X_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(HEIGHT - 1);

  logic [CW-1:0] x_reg;
  logic [CW-1:0] y_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (clr) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (en) begin
      if (last_col) begin
        x_reg <= '0;
        y_reg <= last_row ? '0 : y_reg + 1'b1;
      end else begin
        x_reg <= x_reg + 1'b1;
      end
    end
  end

  assign x        = x_reg;
  assign y        = y_reg;
  assign last_col = (x_reg == X_LAST);
  assign last_row = (y_reg == Y_LAST);

endmodule

// File: rtl/frame_sequencer.sv
// Front-end controller for the pixel pipeline.
// Accepts a valid/ready RGB stream, drives pix_en/hsync/vsync/pix_data,
// inserts vertical and horizontal blanking, flushes the row buffers with
// zero pixels at end of frame, and tags the pipeline output with
// out_valid/out_x/out_y so capture logic needs no latency knowledge.
//   clk, reset_n     : clock, asynchronous active-low reset
//   start            : begin one frame when idle
//   src              : pixel stream (slave side)
//   pix_en, pix_data : pipeline advance enable and pixel
//   hsync, vsync     : new-row / new-frame pulses
//   out_valid        : pipeline output is a real frame pixel
//   out_x, out_y     : coordinate of that output pixel
//   busy             : not idle
//   frame_done       : one-cycle pulse after the flush
//   frame_count      : completed frames, wrapping
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT,
  parameter int HBLANK       = 4,
  parameter int VBLANK       = 2,
  parameter int PIPE_LATENCY = 2 * DEFAULT_FRAME_WIDTH + 2,
  parameter int CW           = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  frame_sequencer_if.slave      src,
  output logic                  pix_en,
  output logic                  hsync,
  output logic                  vsync,
  output logic [PIXEL_SIZE-1:0] pix_data,
  output logic                  out_valid,
  output logic [CW-1:0]         out_x,
  output logic [CW-1:0]         out_y,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CW-1:0]         frame_count
);

  localparam int TW = $clog2(max3(VBLANK, HBLANK, PIPE_LATENCY) + 1);
  localparam int EW = $clog2(PIPE_LATENCY + 1);

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg;
  logic [EW-1:0]   enc_reg;
  logic            hsync_reg, vsync_reg, busy_reg, frame_done_reg;
  logic [CW-1:0]   frame_count_reg;

  logic            frame_start;
  logic            xfer;
  logic [CW-1:0]   col, row;
  logic            last_col, last_row;
  logic            out_last_col, out_last_row;

  assign frame_start = (state_reg == ST_IDLE) && start;
  assign xfer        = (state_reg == ST_ACTIVE) && src.in_valid;

  // Input raster position: advances on every accepted pixel.
  frame_sequencer_coord_counter #(
    .CW(CW), .WIDTH(FRAME_WIDTH), .HEIGHT(FRAME_HEIGHT)
  ) u_in_coord (
    .clk(clk), .reset_n(reset_n), .clr(frame_start), .en(xfer),
    .x(col), .y(row), .last_col(last_col), .last_row(last_row)
  );

  // Output raster position: advances on every aligned output pixel.
  frame_sequencer_coord_counter #(
    .CW(CW), .WIDTH(FRAME_WIDTH), .HEIGHT(FRAME_HEIGHT)
  ) u_out_coord (
    .clk(clk), .reset_n(reset_n), .clr(frame_start), .en(out_valid),
    .x(out_x), .y(out_y), .last_col(out_last_col), .last_row(out_last_row)
  );

  // The sequencer only needs the input counter's flags and the output
  // counter's position; the remaining counter outputs are left idle.
  logic unused_coord_bits;
  assign unused_coord_bits = &{1'b0, col, row, out_last_col, out_last_row};

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      timer_reg       <= '0;
      enc_reg         <= '0;
      hsync_reg       <= 1'b0;
      vsync_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      state_reg <= state_next;

      // Phase timer restarts on every state change and only runs in the
      // fixed-length states.
      if (state_next != state_reg || state_reg == ST_ACTIVE || state_reg == ST_IDLE)
        timer_reg <= '0;
      else
        timer_reg <= timer_reg + 1'b1;

      // Enabled-cycle count since frame start; saturates once the
      // pipeline is full so out_valid stays up from then on.
      if (frame_start)
        enc_reg <= '0;
      else if (pix_en && enc_reg != EW'(PIPE_LATENCY))
        enc_reg <= enc_reg + 1'b1;

      // Sync pulses are registered on the entry edge so they cover the
      // first cycle of the blanking interval.
      vsync_reg      <= frame_start;
      hsync_reg      <= (state_reg == ST_ACTIVE) && (state_next == ST_HBLANK);
      frame_done_reg <= (state_next == ST_DONE);
      busy_reg       <= (state_next != ST_IDLE);

      if (state_reg == ST_DONE)
        frame_count_reg <= frame_count_reg + 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start) state_next = ST_VBLANK;
      ST_VBLANK: if (timer_reg == TW'(VBLANK - 1)) state_next = ST_ACTIVE;
      ST_ACTIVE: if (xfer && last_col) state_next = last_row ? ST_FLUSH : ST_HBLANK;
      ST_HBLANK: if (timer_reg == TW'(HBLANK - 1)) state_next = ST_ACTIVE;
      ST_FLUSH:  if (timer_reg == TW'(PIPE_LATENCY - 1)) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Combinational outputs.
  always_comb begin
    src.in_ready = (state_reg == ST_ACTIVE);
    pix_en       = xfer || (state_reg == ST_FLUSH);
    pix_data     = xfer ? src.in_data : '0;
    out_valid    = pix_en && (enc_reg == EW'(PIPE_LATENCY));
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign busy        = busy_reg;
  assign frame_done  = frame_done_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer on a 4x3 frame, 2-cycle blanking,
// 10-cycle pipeline latency and 2-bit counters.
module tb_frame_sequencer;
  import frame_sequencer_pkg::*;

  localparam int FW = 4;
  localparam int FH = 3;
  localparam int HB = 2;
  localparam int VB = 2;
  localparam int PL = 10;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic pix_en, hsync, vsync, out_valid, busy, frame_done;
  logic [PIXEL_SIZE-1:0] pix_data;
  logic [CW-1:0] out_x, out_y, frame_count;

  frame_sequencer_if src_bus ();

  frame_sequencer #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .HBLANK(HB), .VBLANK(VB),
    .PIPE_LATENCY(PL), .CW(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src(src_bus),
    .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .pix_data(pix_data),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc, n_pen, n_ov, n_vs, n_hs, n_xfer, n_fd, fd_cyc, ex, ey;
  logic prev_pen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: inputs are already driven; sample at the falling edge.
  task automatic sample();
    @(negedge clk);
    cyc++;
    if (src_bus.in_valid && src_bus.in_ready) n_xfer++;
    if (n_pen < FW * FH && !src_bus.in_valid) begin
      chk("stall_no_en", {31'd0, pix_en}, 32'd0);
      chk("stall_data_zero", 32'(pix_data), 32'd0);
    end
    if (pix_en) begin
      n_pen++;
      if (n_pen <= FW * FH) chk("pix_data_active", 32'(pix_data), 32'(n_pen));
      else                  chk("pix_data_flush", 32'(pix_data), 32'd0);
    end
    if (vsync) n_vs++;
    if (hsync) begin
      n_hs++;
      chk("hsync_after_row_end", {31'd0, prev_pen}, 32'd1);
      chk("hsync_no_en", {31'd0, pix_en}, 32'd0);
    end
    if (out_valid) begin
      n_ov++;
      chk("ov_on_pen_11_to_22", {31'd0, (pix_en && n_pen >= PL + 1)}, 32'd1);
      chk("out_x", 32'(out_x), 32'(ex));
      chk("out_y", 32'(out_y), 32'(ey));
      ex++;
      if (ex == FW) begin
        ex = 0;
        ey++;
      end
    end
    if (frame_done) begin
      n_fd++;
      fd_cyc = cyc;
      chk("done_after_flush", {31'd0, prev_pen}, 32'd1);
      chk("done_no_en", {31'd0, pix_en}, 32'd0);
      chk("busy_in_done", {31'd0, busy}, 32'd1);
    end
    prev_pen = pix_en;
    @(posedge clk);
    #1;
  endtask

  // mode 0: in_valid held high; mode 1: in_valid 1,0,0,1 pattern;
  // mode 2: in_valid and start held high through the frame.
  // stop_pen != 0 returns early once that many pix_en cycles were seen.
  task automatic run_frame(input int mode, input int fc_exp, input int stop_pen);
    cyc = 0; n_pen = 0; n_ov = 0; n_vs = 0; n_hs = 0; n_xfer = 0;
    n_fd = 0; fd_cyc = 0; ex = 0; ey = 0; prev_pen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      start = (k == 0) || (mode == 2);
      src_bus.in_valid = (mode == 1) ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      src_bus.in_data = PIXEL_SIZE'(n_xfer + 1);
      sample();
      if (n_fd != 0) break;
      if (stop_pen != 0 && n_pen == stop_pen) break;
    end
    if (stop_pen == 0) begin
      chk("frame_done_seen", 32'(n_fd), 32'd1);
      chk("pix_en_total", 32'(n_pen), 32'd22);
      chk("out_valid_total", 32'(n_ov), 32'(FW * FH));
      chk("vsync_cycles", 32'(n_vs), 32'd1);
      chk("hsync_cycles", 32'(n_hs), 32'(FH - 1));
      chk("transfers", 32'(n_xfer), 32'(FW * FH));
      if (mode == 0) chk("done_cycle", 32'(fd_cyc), 32'd30);
      start = 1'b0;
      src_bus.in_valid = 1'b0;
      sample();
      chk("idle_after_frame", {31'd0, busy}, 32'd0);
      chk("single_done", 32'(n_fd), 32'd1);
      chk("frame_count", 32'(frame_count), 32'(fc_exp));
      $display("frame mode=%0d pix_en=%0d out_valid=%0d done_cycle=%0d frame_count=%0d",
               mode, n_pen, n_ov, fd_cyc, frame_count);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_en"}, {31'd0, pix_en}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, src_bus.in_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_vsync_hsync"}, {30'd0, vsync, hsync}, 32'd0);
    chk({tag, "_done_ov"}, {30'd0, frame_done, out_valid}, 32'd0);
    chk({tag, "_out_xy"}, {28'd0, out_x, out_y}, 32'd0);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
  endtask

  initial begin
    src_bus.in_valid = 1'b1;
    src_bus.in_data = 24'h00abcd;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Valid data without start is ignored in IDLE.
    sample();
    chk("idle_ignores_valid", {30'd0, pix_en, src_bus.in_ready}, 32'd0);

    run_frame(0, 1, 0);
    run_frame(1, 2, 0);
    run_frame(2, 3, 0);

    // Abandon a frame mid row 2 with an asynchronous reset.
    run_frame(0, 0, 10);
    chk("en_before_reset", {31'd0, pix_en}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (3) sample();
    chk("no_done_after_reset", 32'(n_fd), 32'd0);
    reset_n = 1'b1;
    $display("reset mid-frame after %0d pix_en", n_pen);

    // Counter wraps at 2^CW.
    run_frame(0, 1, 0);
    run_frame(0, 2, 0);
    run_frame(0, 3, 0);
    run_frame(0, 0, 0);
    run_frame(0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Front-end controller for the pixel pipeline (rgb2i -> row buffers -> sobel_window -> threshold -> connected_components_labeling).
- Accepts a valid/ready RGB pixel stream and drives the pipeline's en/hsync/vsync/data.
- Inserts horizontal and vertical blanking.
- At end of frame, flushes the row buffers with zero pixels.
- Emits out_valid plus output coordinates aligned to the pipeline result, so downstream capture needs no latency knowledge.

Parameters:
FRAME_WIDTH, 550, active pixels per row.
FRAME_HEIGHT, 480, active rows per frame.
HBLANK, 4, cycles between rows; hsync high on the first; range >= 1.
VBLANK, 2, cycles before the first row; vsync high on the first; range >= 1.
PIPE_LATENCY, 1102, enabled cycles from pixel input to aligned output (2*FRAME_WIDTH+2).
CW, 16, coordinate/frame counter width.

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous assert, active-low
start  in  1  pulse; begin one frame when idle
in_valid  in  1  source pixel valid
in_ready  out  1  sequencer accepts pixel
in_data  in  PIXEL_SIZE  source RGB pixel
pix_en  out  1  pipeline advance enable
hsync  out  1  new-row pulse to pipeline
vsync  out  1  new-frame pulse to pipeline
pix_data  out  PIXEL_SIZE  pixel to pipeline
out_valid  out  1  pipeline output is a real frame pixel
out_x  out  CW  column of current output pixel
out_y  out  CW  row of current output pixel
busy  out  1  not in IDLE
frame_done  out  1  one-cycle pulse at end of flush
frame_count  out  CW  completed frames, wraps at 2^CW

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE.
  - All outputs 0; all counters 0.
  - Reset mid-frame abandons the frame; no frame_done.
- States: IDLE, VBLANK, ACTIVE, HBLANK, FLUSH, DONE.
- IDLE:
  - start=1 -> VBLANK next cycle.
  - in_ready=0.
- VBLANK:
  - Lasts exactly VBLANK cycles.
  - vsync=1 in the first cycle only.
  - pix_en=0.
  - Then ACTIVE with row=0, col=0.
- ACTIVE:
  - in_ready=1, combinational with state.
  - Transfer when in_valid & in_ready: pix_en=1, pix_data=in_data, col++.
  - No transfer: pix_en=0, pix_data=0 (stall; pipeline holds).
  - Transfer of col=FRAME_WIDTH-1:
    - Not last row -> HBLANK, col=0, row++.
    - Last row -> FLUSH.
- HBLANK:
  - Lasts HBLANK cycles.
  - hsync=1 in the first cycle only.
  - pix_en=0, in_ready=0.
  - Then ACTIVE.
- FLUSH:
  - Lasts exactly PIPE_LATENCY cycles.
  - pix_en=1, pix_data=0 every cycle; in_ready=0.
  - Then DONE.
- DONE:
  - One cycle; frame_done=1, frame_count++.
  - Then IDLE.
- Output alignment:
  - enc = count of pix_en cycles since VBLANK entry, saturating at PIPE_LATENCY.
  - out_valid = pix_en & (enc == PIPE_LATENCY), evaluated before the increment.
  - Hence exactly FRAME_WIDTH*FRAME_HEIGHT out_valid cycles per frame.
- Output coordinates:
  - out_x/out_y start at 0,0.
  - Advance after each out_valid cycle.
  - out_x wraps FRAME_WIDTH-1 -> 0 with out_y++.
  - Cleared on VBLANK entry.
- All outputs are registered except in_ready, pix_en, pix_data, out_valid (combinational from state, registered counters, in_valid, in_data).
- Ignored inputs:
  - start while busy.
  - in_valid outside ACTIVE (no transfer, no data latched).
- busy=1 in every state except IDLE.
- start in the DONE cycle is ignored; a new start is accepted in IDLE.

Decomposition:
- global.vh holds:
  - PIXEL_SIZE, WORD_SIZE.
  - State encodings (3-bit localparams) for IDLE..DONE.
  - Default FRAME_WIDTH/FRAME_HEIGHT, also used by top.
- One sub-module, coord_counter: CW-bit x/y counter with enable, synchronous clear, wrap at a width parameter, and last-column/last-row flags.
  - Instantiated twice: input col/row and output out_x/out_y.

Test Plan:
Use FRAME_WIDTH=4, FRAME_HEIGHT=3, HBLANK=2, VBLANK=2, PIPE_LATENCY=10 unless noted.
1. Reset, then start pulse, in_valid held 1 -> vsync high one cycle; rows of 4 pix_en separated by 2-cycle gaps with hsync on the first gap cycle; FLUSH of 10 pix_en with pix_data=0; frame_done one cycle after FLUSH; frame_count=1; 22 total pix_en.
2. Same run, count alignment -> out_valid exactly 12 cycles, on pix_en numbers 11..22; (out_x,out_y) sequence (0,0),(1,0)...(3,2).
3. in_valid toggled 1,0,0,1 pattern in ACTIVE -> pix_en only on transfer cycles; pix_data=0 on stalls; col unchanged over stalls; same 12 out_valid.
4. start pulsed while busy and in_valid=1 during HBLANK/FLUSH -> no restart; in_ready=0; no extra transfers; frame_count increments once.
5. reset_n driven low mid-row 2 (asynchronously, between clock edges) -> outputs 0 immediately; state IDLE; no frame_done; next start yields a full correct frame with frame_count=1.
6. frame_count with CW=2 over 5 frames -> values 1,2,3,0,1 after each frame_done.
